// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with a fixed 33-cycle issue-to-writeback latency.
// Build option: define MULDIV_DIV_EN to include the divider; without it ops 4-7 write back zero.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   // Issue handshake: start_i is taken only while busy_o is low (state IDLE); busy_o then stays
   // high until the cycle after done_o, so the caller simply stalls on busy_o and needs no ready.
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_val_i,
   input  logic [XLEN-1:0] rs2_val_i,
   input  logic [4:0]      rd_addr_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            wb_we_o,
   output logic [4:0]      wb_wa_o,
   output logic [XLEN-1:0] wb_wd_o,
   output logic [1:0]      dbg_state_o
);

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_REM    = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state_q;
   logic [2:0]        op_q;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   mcand_q;
   logic [XLEN-1:0]   hi_q;
   logic [XLEN-1:0]   lo_q;
   logic              neg_q;
   logic [4:0]        cnt_q;
   logic              busy_q;
   logic              done_q;
   logic              wb_we_q;
   logic [4:0]        wb_wa_q;
   logic [XLEN-1:0]   wb_wd_q;

`ifdef MULDIV_DIV_EN
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
   logic [XLEN-1:0]   rs1_q;
   logic              dzero_q;
   logic              ovf_q;
   logic              dzero_d;
   logic              ovf_d;
   logic [XLEN:0]     part_rem;
   logic              rem_fits;
   logic [XLEN-1:0]   div_v;
`endif

   // Operand conditioning at issue: magnitudes plus the sign the result must carry.
   logic              rs1_signed;
   logic              rs2_signed;
   logic              rs1_neg;
   logic              rs2_neg;
   logic [XLEN-1:0]   rs1_mag;
   logic [XLEN-1:0]   rs2_mag;
   logic              neg_d;

   always_comb begin
      rs1_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
      rs2_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
      rs1_neg    = rs1_signed & rs1_val_i[XLEN-1];
      rs2_neg    = rs2_signed & rs2_val_i[XLEN-1];
      rs1_mag    = rs1_neg ? -rs1_val_i : rs1_val_i;
      rs2_mag    = rs2_neg ? -rs2_val_i : rs2_val_i;
      neg_d      = (op_i == OP_REM) ? rs1_neg : (rs1_neg ^ rs2_neg);
   end

`ifdef MULDIV_DIV_EN
   always_comb begin
      dzero_d = (rs2_val_i == '0);
      ovf_d   = !op_i[0] && (rs1_val_i == INT_MIN) && (rs2_val_i == '1);
   end
`endif

   // One iteration. lo_q carries rs1's magnitude in both modes: multiplier bits shift out
   // LSB first, or dividend bits shift out MSB first while quotient bits shift in.
   logic [XLEN:0]     mul_sum;
   logic [XLEN-1:0]   hi_d;
   logic [XLEN-1:0]   lo_d;

   always_comb begin
      mul_sum = {1'b0, hi_q} + {1'b0, mcand_q & {XLEN{lo_q[0]}}};
      hi_d    = mul_sum[XLEN:1];
      lo_d    = {mul_sum[0], lo_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
      part_rem = {hi_q, lo_q[XLEN-1]};
      rem_fits = (part_rem >= {1'b0, mcand_q});
      if (op_q[2]) begin
         hi_d = rem_fits ? XLEN'(part_rem - {1'b0, mcand_q}) : part_rem[XLEN-1:0];
         lo_d = {lo_q[XLEN-2:0], rem_fits};
      end
`endif
   end

   // Result selection for the FIX cycle.
   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   res_d;

   always_comb begin
      prod   = {hi_q, lo_q};
      prod_s = neg_q ? -prod : prod;
      res_d  = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
      div_v = op_q[1] ? hi_q : lo_q;
      if (op_q[2]) begin
         res_d = neg_q ? -div_v : div_v;
         if (dzero_q) begin
            res_d = op_q[1] ? rs1_q : '1;
         end else if (ovf_q) begin
            res_d = op_q[1] ? '0 : INT_MIN;
         end
      end
`else
      if (op_q[2]) begin
         res_d = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         rd_q    <= '0;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wb_we_q <= 1'b0;
         wb_wa_q <= '0;
         wb_wd_q <= '0;
`ifdef MULDIV_DIV_EN
         rs1_q   <= '0;
         dzero_q <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q <= S_CALC;
                  busy_q  <= 1'b1;
                  op_q    <= op_i;
                  rd_q    <= rd_addr_i;
                  mcand_q <= rs2_mag;
                  lo_q    <= rs1_mag;
                  hi_q    <= '0;
                  neg_q   <= neg_d;
                  cnt_q   <= 5'd31;
`ifdef MULDIV_DIV_EN
                  rs1_q   <= rs1_val_i;
                  dzero_q <= dzero_d;
                  ovf_q   <= ovf_d;
`endif
               end
            end
            S_CALC: begin
               hi_q <= hi_d;
               lo_q <= lo_d;
               if (cnt_q == 5'd0) begin
                  state_q <= S_FIX;
               end else begin
                  cnt_q <= cnt_q - 5'd1;
               end
            end
            S_FIX: begin
               state_q <= S_DONE;
               done_q  <= 1'b1;
               wb_we_q <= (rd_q != 5'd0);
               wb_wa_q <= rd_q;
               wb_wd_q <= res_d;
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               wb_we_q <= 1'b0;
               wb_wd_q <= '0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign wb_we_o     = wb_we_q;
   assign wb_wa_o     = wb_wa_q;
   assign wb_wd_o     = wb_wd_q;
   assign dbg_state_o = state_q;

endmodule
